// File: rtl/cache_l0_pkg.sv
// rtl/cache_l0_pkg.sv - shared types and width helpers for the L0 refill path
package cache_l0_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FILL  = 2'd2,
    ST_WRITE = 2'd3
  } refill_state_e;

  // Byte offset bits within a line: word select plus byte-in-word select.
  function automatic int offset_w(input int log2_wpl, input int data_w);
    return log2_wpl + $clog2(data_w / 8);
  endfunction

  // Tag bits left above the line offset.
  function automatic int tag_w(input int addr_w, input int log2_wpl, input int data_w);
    return addr_w - offset_w(log2_wpl, data_w);
  endfunction

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_LOG2_WPL = 2;
  localparam int DEF_OFFSET_W = offset_w(DEF_LOG2_WPL, DEF_DATA_W);
  localparam int DEF_TAG_W    = tag_w(DEF_ADDR_W, DEF_LOG2_WPL, DEF_DATA_W);

  typedef logic [DEF_DATA_W*(1<<DEF_LOG2_WPL)-1:0] line_t;

endpackage

// File: rtl/cache_line_buf.sv
// rtl/cache_line_buf.sv - word-indexed line assembly register
module cache_line_buf
  import cache_l0_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int LOG2_WPL = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [LOG2_WPL-1:0]              wr_idx,
  input  logic [DATA_W-1:0]                wr_data,
  output logic [DATA_W*(1<<LOG2_WPL)-1:0]  line
);

  // Drop each arriving word into its slot; the whole line is always readable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= '0;
    end else if (wr_en) begin
      line[wr_idx*DATA_W +: DATA_W] <= wr_data;
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - L0 miss refill FSM (optional early restart: CACHE_REFILL_BYPASS_EN)
module cache_refill_ctrl
  import cache_l0_pkg::*;
#(
  parameter  int LOG2_NUM_BLKS = 3,
  parameter  int ADDR_W        = 32,
  parameter  int DATA_W        = 32,
  parameter  int LOG2_WPL      = 2,
  localparam int OFFSET_W      = offset_w(LOG2_WPL, DATA_W),
  localparam int TAG_W         = tag_w(ADDR_W, LOG2_WPL, DATA_W),
  localparam int LINE_W        = DATA_W * (1 << LOG2_WPL)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_i,
  input  logic [ADDR_W-1:0]        miss_addr_i,
  output logic                     busy_o,
  output logic                     algo_en_o,
  input  logic [LOG2_NUM_BLKS-1:0] rplc_line_idx_i,
  output logic                     mem_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  output logic                     wr_en_o,
  output logic [LOG2_NUM_BLKS-1:0] wr_line_idx_o,
  output logic [TAG_W-1:0]         wr_tag_o,
  output logic [LINE_W-1:0]        wr_data_o,
  output logic                     done_o,
  output logic                     byp_valid_o,
  output logic [DATA_W-1:0]        byp_data_o
);

  localparam int BYTE_W = OFFSET_W - LOG2_WPL;
  localparam logic [LOG2_WPL-1:0] LAST_BEAT = LOG2_WPL'((1 << LOG2_WPL) - 1);

  refill_state_e state, next_state;

  logic [TAG_W-1:0]         tag_q;
  logic [LOG2_NUM_BLKS-1:0] idx_q;
  logic [LOG2_WPL-1:0]      beat_cnt;
  logic [LINE_W-1:0]        line;
  logic                     capture;
  logic                     beat_fire;

  assign capture   = (state == ST_IDLE) && miss_i;
  assign beat_fire = (state == ST_FILL) && mem_rvalid_i;

  // State register; an async reset mid-burst abandons the refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Latch the miss context (pre-advance victim index) and count beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q    <= '0;
      idx_q    <= '0;
      beat_cnt <= '0;
    end else begin
      if (capture) begin
        tag_q <= miss_addr_i[ADDR_W-1:OFFSET_W];
        idx_q <= rplc_line_idx_i;
      end
      if ((state == ST_REQ) && mem_gnt_i) beat_cnt <= '0;
      else if (beat_fire)                 beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Next-state and strobe decode; stray inputs in other states fall through.
  always_comb begin
    next_state = state;
    algo_en_o  = 1'b0;
    mem_req_o  = 1'b0;
    wr_en_o    = 1'b0;
    done_o     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (miss_i) begin
          algo_en_o  = 1'b1;
          next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) next_state = ST_FILL;
      end
      ST_FILL: begin
        if (mem_rvalid_i && (beat_cnt == LAST_BEAT)) next_state = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en_o    = 1'b1;
        done_o     = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  cache_line_buf #(
    .DATA_W   (DATA_W),
    .LOG2_WPL (LOG2_WPL)
  ) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (beat_fire),
    .wr_idx  (beat_cnt),
    .wr_data (mem_rdata_i),
    .line    (line)
  );

  assign busy_o        = (state != ST_IDLE);
  assign mem_addr_o    = mem_req_o ? {tag_q, {OFFSET_W{1'b0}}} : '0;
  assign wr_line_idx_o = wr_en_o ? idx_q : '0;
  assign wr_tag_o      = wr_en_o ? tag_q : '0;
  assign wr_data_o     = wr_en_o ? line  : '0;

`ifdef CACHE_REFILL_BYPASS_EN
  logic [LOG2_WPL-1:0] woff_q;
  logic                byp_valid_q;
  logic [DATA_W-1:0]   byp_data_q;
  logic                unused_addr;

  assign unused_addr = &{1'b0, miss_addr_i[BYTE_W-1:0]};

  // Forward the critical word one clock after it lands, ahead of the line write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      woff_q      <= '0;
      byp_valid_q <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      if (capture) woff_q <= miss_addr_i[OFFSET_W-1:BYTE_W];
      byp_valid_q <= beat_fire && (beat_cnt == woff_q);
      byp_data_q  <= (beat_fire && (beat_cnt == woff_q)) ? mem_rdata_i : '0;
    end
  end

  assign byp_valid_o = byp_valid_q;
  assign byp_data_o  = byp_data_q;
`else
  logic unused_addr;

  assign unused_addr = &{1'b0, miss_addr_i[OFFSET_W-1:0]};
  assign byp_valid_o = 1'b0;
  assign byp_data_o  = '0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - directed self-checking bench for cache_refill_ctrl
`timescale 1ns/1ps
module tb_cache_refill_ctrl;

`ifdef CACHE_REFILL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         miss_i;
  logic [31:0]  miss_addr_i;
  logic         busy_o;
  logic         algo_en_o;
  logic [2:0]   rplc_line_idx_i;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_gnt_i;
  logic         mem_rvalid_i;
  logic [31:0]  mem_rdata_i;
  logic         wr_en_o;
  logic [2:0]   wr_line_idx_o;
  logic [27:0]  wr_tag_o;
  logic [127:0] wr_data_o;
  logic         done_o;
  logic         byp_valid_o;
  logic [31:0]  byp_data_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .miss_i          (miss_i),
    .miss_addr_i     (miss_addr_i),
    .busy_o          (busy_o),
    .algo_en_o       (algo_en_o),
    .rplc_line_idx_i (rplc_line_idx_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .wr_en_o         (wr_en_o),
    .wr_line_idx_o   (wr_line_idx_o),
    .wr_tag_o        (wr_tag_o),
    .wr_data_o       (wr_data_o),
    .done_o          (done_o),
    .byp_valid_o     (byp_valid_o),
    .byp_data_o      (byp_data_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input logic [31:0] addr, input logic [2:0] idx, input logic [127:0] line,
                        input int stall, input logic [31:0] exp_maddr, input logic [27:0] exp_tag);
    logic [1:0]  woff;
    logic        exp_bv;
    logic [31:0] exp_bd;
    woff = addr[3:2];
    miss_i = 1'b1; miss_addr_i = addr; rplc_line_idx_i = idx;
    #1;
    chk("miss_algo_en", algo_en_o, 1'b1);
    chk("miss_busy", busy_o, 1'b0);
    tick();
    rplc_line_idx_i = idx + 3'd1;
    for (int s = 0; s <= stall; s++) begin
      mem_gnt_i = (s == stall);
      #1;
      chk("req_valid", mem_req_o, 1'b1);
      chk("req_addr", mem_addr_o, exp_maddr);
      chk("req_no_algo", algo_en_o, 1'b0);
      tick();
    end
    mem_gnt_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = line[b*32 +: 32];
      #1;
      chk("fill_no_wr", wr_en_o, 1'b0);
      chk("fill_no_algo", algo_en_o, 1'b0);
      exp_bv = BYP && (b > 0) && (woff == 2'(b - 1));
      exp_bd = exp_bv ? line[(b-1)*32 +: 32] : 32'h0;
      chk("fill_byp_valid", byp_valid_o, exp_bv);
      if (exp_bv || !BYP) chk("fill_byp_data", byp_data_o, exp_bd);
      tick();
    end
    mem_rvalid_i = 1'b0;
    #1;
    chk("write_en", wr_en_o, 1'b1);
    chk("write_done", done_o, 1'b1);
    chk("write_idx", wr_line_idx_o, idx);
    chk("write_tag", wr_tag_o, exp_tag);
    chk("write_data", wr_data_o, line);
    exp_bv = BYP && (woff == 2'd3);
    chk("write_byp_valid", byp_valid_o, exp_bv);
    if (exp_bv || !BYP) chk("write_byp_data", byp_data_o, exp_bv ? line[127:96] : 32'h0);
    miss_i = 1'b0;
    tick();
    #1;
    chk("after_no_wr", wr_en_o, 1'b0);
    chk("after_idle", busy_o, 1'b0);
    chk("after_wr_data", wr_data_o, 128'h0);
    chk("after_byp_valid", byp_valid_o, 1'b0);
  endtask

  initial begin
    bit pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; miss_i = 1'b0; miss_addr_i = '0; rplc_line_idx_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    #3;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_algo", algo_en_o, 1'b0);
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_wr", wr_en_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_byp", byp_valid_o, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic refill, immediate grant
    refill(32'h0000_1234, 3'd5, 128'hA000_0003_A000_0002_A000_0001_A000_0000,
           0, 32'h0000_1230, 28'h0000123);

    // Grant stalled three cycles
    refill(32'h0000_ABC8, 3'd2, 128'hB000_0003_B000_0002_B000_0001_B000_0000,
           3, 32'h0000_ABC0, 28'h0000ABC);

    // Gaps in rvalid
    miss_i = 1'b1; miss_addr_i = 32'h0000_0040; rplc_line_idx_i = 3'd7;
    #1; chk("gap_algo", algo_en_o, 1'b1);
    tick();
    rplc_line_idx_i = 3'd0; mem_gnt_i = 1'b1;
    #1; chk("gap_req_addr", mem_addr_o, 32'h0000_0040);
    tick();
    mem_gnt_i = 1'b0;
    begin
      int k;
      k = 0;
      for (int i = 0; i < 7; i++) begin
        mem_rvalid_i = pat[i];
        mem_rdata_i  = pat[i] ? (32'hC000_0000 + 32'(k)) : 32'hDEAD_BEEF;
        #1;
        chk("gap_no_wr", wr_en_o, 1'b0);
        chk("gap_no_algo", algo_en_o, 1'b0);
        if (pat[i]) k++;
        tick();
      end
    end
    mem_rvalid_i = 1'b0;
    #1;
    chk("gap_wr", wr_en_o, 1'b1);
    chk("gap_idx", wr_line_idx_o, 3'd7);
    chk("gap_tag", wr_tag_o, 28'h0000004);
    chk("gap_data", wr_data_o, 128'hC000_0003_C000_0002_C000_0001_C000_0000);
    miss_i = 1'b0;
    tick();
    #1; chk("gap_idle", busy_o, 1'b0);

    // Stray rvalid in REQ/WRITE, miss held through the refill
    miss_i = 1'b1; miss_addr_i = 32'h0000_0100; rplc_line_idx_i = 3'd1;
    #1; chk("stray_algo", algo_en_o, 1'b1);
    tick();
    rplc_line_idx_i = 3'd2; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_0000;
    #1; chk("stray_req", mem_req_o, 1'b1); chk("stray_no_algo_req", algo_en_o, 1'b0);
    tick();
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
    #1; chk("stray_req2", mem_req_o, 1'b1);
    tick();
    mem_gnt_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hD000_0000 + 32'(b);
      #1;
      chk("stray_no_algo", algo_en_o, 1'b0);
      chk("stray_no_wr", wr_en_o, 1'b0);
      chk("stray_busy", busy_o, 1'b1);
      tick();
    end
    mem_rdata_i = 32'hBAD1_0000;
    #1;
    chk("stray_wr", wr_en_o, 1'b1);
    chk("stray_idx", wr_line_idx_o, 3'd1);
    chk("stray_data", wr_data_o, 128'hD000_0003_D000_0002_D000_0001_D000_0000);
    chk("stray_no_algo_wr", algo_en_o, 1'b0);
    miss_i = 1'b0; mem_rvalid_i = 1'b0;
    tick();
    #1; chk("stray_one_write", wr_en_o, 1'b0); chk("stray_idle", busy_o, 1'b0);
    tick();
    #1; chk("stray_one_write2", wr_en_o, 1'b0);

    // Reset after two beats
    miss_i = 1'b1; miss_addr_i = 32'h0000_0200; rplc_line_idx_i = 3'd3;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hE000_0000 + 32'(b);
      tick();
    end
    mem_rvalid_i = 1'b0; miss_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy_o, 1'b0);
    chk("mrst_req", mem_req_o, 1'b0);
    chk("mrst_wr", wr_en_o, 1'b0);
    chk("mrst_done", done_o, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    #1; chk("mrst_no_write", wr_en_o, 1'b0);
    refill(32'h0000_0300, 3'd4, 128'hF000_0003_F000_0002_F000_0001_F000_0000,
           0, 32'h0000_0300, 28'h0000030);

    // Critical word at offset 2 (early restart when enabled)
    refill(32'h0000_1238, 3'd6, 128'h9000_0003_9000_0002_9000_0001_9000_0000,
           1, 32'h0000_1230, 28'h0000123);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
